// File: rtl/tstate_sequencer_if.sv
// Ring-side bus of the T-state sequencer: one-hot state and decoded length in,
// T-state index, ring clear, end-of-instruction and error status out.
interface tstate_sequencer_if #(
  parameter int unsigned NSTATES = 18
);
  logic [NSTATES-1:0] state;
  logic               len_valid;
  logic [4:0]         len;
  logic [4:0]         tstate_idx;
  logic               nclr_ring;
  logic               instr_done;
  logic               seq_err;
  logic [1:0]         err_code;

  modport master (
    output state, len_valid, len,
    input  tstate_idx, nclr_ring, instr_done, seq_err, err_code
  );

  modport slave (
    input  state, len_valid, len,
    output tstate_idx, nclr_ring, instr_done, seq_err, err_code
  );
endinterface

// File: rtl/tstate_sequencer.sv
// Terminates each instruction on the T-state ring after its own length and
// checks ring sequencing. Define TSEQ_CHECK_EN to build the checker and ERR state.
module tstate_sequencer #(
  parameter int unsigned NSTATES    = 18,
  parameter int unsigned FETCH_LAST = 3
) (
  input logic               CLK,
  input logic               CLR,
  tstate_sequencer_if.slave bus
);
  localparam int unsigned   IW        = 5;
  localparam logic [IW-1:0] IDX_FIRST = IW'(1);
  localparam logic [IW-1:0] IDX_FL    = IW'(FETCH_LAST);
  localparam logic [IW-1:0] IDX_MIN   = IW'(FETCH_LAST + 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NSTATES);

`ifdef TSEQ_CHECK_EN
  typedef enum logic [1:0] {SYNC, FETCH, EXEC, ERR} fsm_t;
`else
  typedef enum logic [1:0] {SYNC, FETCH, EXEC} fsm_t;
`endif

  fsm_t          fsm_q, fsm_d;
  logic [IW-1:0] len_q, len_d;
  logic          nclr_q, nclr_d;
  logic          done_q, done_d;
  logic [IW-1:0] idx_c;
  logic          onehot_c;
  logic [IW-1:0] len_sel_c;

`ifdef TSEQ_CHECK_EN
  logic [IW-1:0] prev_q, prev_d;
  logic          wrap_q, wrap_d;
  logic          seq_err_q, seq_err_d;
  logic [1:0]    err_q, err_d;
  logic [IW-1:0] exp_c;
  logic [1:0]    cause_c;
`endif

  // One-hot to binary; anything not exactly one-hot encodes as 0
  always_comb begin
    idx_c    = '0;
    onehot_c = (bus.state != '0) && ((bus.state & (bus.state - NSTATES'(1))) == '0);
    for (int i = 0; i < int'(NSTATES); i++) begin
      if (bus.state[i]) idx_c = IW'(i + 1);
    end
    if (!onehot_c) idx_c = '0;
  end

  // Length to latch at FETCH_LAST: clamped, or full ring when none is offered
  always_comb begin
    if (!bus.len_valid)          len_sel_c = IDX_LAST;
    else if (bus.len < IDX_MIN)  len_sel_c = IDX_MIN;
    else if (bus.len > IDX_LAST) len_sel_c = IDX_LAST;
    else                         len_sel_c = bus.len;
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      fsm_q     <= SYNC;
      len_q     <= IDX_LAST;
      nclr_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef TSEQ_CHECK_EN
      prev_q    <= '0;
      wrap_q    <= 1'b0;
      seq_err_q <= 1'b0;
      err_q     <= 2'b00;
`endif
    end else begin
      fsm_q     <= fsm_d;
      len_q     <= len_d;
      nclr_q    <= nclr_d;
      done_q    <= done_d;
`ifdef TSEQ_CHECK_EN
      prev_q    <= prev_d;
      wrap_q    <= wrap_d;
      seq_err_q <= seq_err_d;
      err_q     <= err_d;
`endif
    end
  end

  always_comb begin
    fsm_d  = fsm_q;
    len_d  = len_q;
    nclr_d = 1'b1;
    done_d = 1'b0;
`ifdef TSEQ_CHECK_EN
    prev_d    = prev_q;
    wrap_d    = wrap_q;
    seq_err_d = seq_err_q;
    err_d     = err_q;
    exp_c     = wrap_q ? IDX_FIRST : prev_q + IW'(1);
    // Cause priority: not one-hot, then out of order, then missing length
    if (idx_c == '0)
      cause_c = 2'b01;
    else if (idx_c != exp_c)
      cause_c = 2'b10;
    else if (fsm_q == FETCH && idx_c == IDX_FL && !bus.len_valid)
      cause_c = 2'b11;
    else
      cause_c = 2'b00;
`endif

    case (fsm_q)
      // Wait for T01 from a free-running ring, not one still being cleared
      SYNC: begin
        if (idx_c == IDX_FIRST && nclr_q) begin
          fsm_d = FETCH;
`ifdef TSEQ_CHECK_EN
          prev_d = IDX_FIRST;
          wrap_d = 1'b0;
`endif
        end
      end
      FETCH, EXEC: begin
`ifdef TSEQ_CHECK_EN
        if (cause_c != 2'b00) begin
          fsm_d     = ERR;
          err_d     = cause_c;
          seq_err_d = 1'b1;
          nclr_d    = 1'b0;
        end else begin
          prev_d = idx_c;
          wrap_d = 1'b0;
`else
        if (idx_c == '0) begin
          nclr_d = nclr_q;
          done_d = done_q;
        end else begin
`endif
          if (fsm_q == FETCH) begin
            if (idx_c == IDX_FL) begin
              len_d = len_sel_c;
              fsm_d = EXEC;
              // Shortest instruction ends in the T-state right after fetch
              if (len_sel_c == IDX_MIN) begin
                nclr_d = 1'b0;
                done_d = 1'b1;
              end
            end
          end else if (done_q) begin
            fsm_d = FETCH;
`ifdef TSEQ_CHECK_EN
            wrap_d = 1'b1;
`endif
          end else if (idx_c == len_q - IW'(1)) begin
            nclr_d = 1'b0;
            done_d = 1'b1;
          end
        end
      end
`ifdef TSEQ_CHECK_EN
      ERR: begin
        nclr_d = 1'b0;
      end
`endif
      default: fsm_d = SYNC;
    endcase
  end

  assign bus.tstate_idx = idx_c;
  assign bus.nclr_ring  = nclr_q;
  assign bus.instr_done = done_q;
`ifdef TSEQ_CHECK_EN
  assign bus.seq_err    = seq_err_q;
  assign bus.err_code   = err_q;
`else
  assign bus.seq_err    = 1'b0;
  assign bus.err_code   = 2'b00;
`endif
endmodule

// File: tb/tb_tstate_sequencer.sv
// Directed bench for tstate_sequencer with a behavioural model of the T-state ring.
module tb_tstate_sequencer;
  localparam int NS = 18;
  localparam int FL = 3;

  logic          CLK;
  logic          CLR;
  logic [NS-1:0] ring;
  int            n_checks;
  int            n_fail;

  tstate_sequencer_if #(.NSTATES(NS)) bus ();

  tstate_sequencer #(.NSTATES(NS), .FETCH_LAST(FL)) dut (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: ring clears to T01 while nclr_ring is low, otherwise rotates
  task automatic tick();
    logic n;
    n = bus.nclr_ring;
    @(posedge CLK);
    #1;
    if (n !== 1'b1) ring = NS'(1);
    else            ring = {ring[NS-2:0], ring[NS-1]};
    bus.state = ring;
    #1;
  endtask

  // Reset for ncyc cycles; returns in the first T01 cycle with the ring free
  task automatic do_reset(input int ncyc);
    CLR = 1'b1;
    for (int i = 0; i < ncyc; i++) tick();
    check("rst nclr", 32'(bus.nclr_ring), 0);
    check("rst done", 32'(bus.instr_done), 0);
    check("rst seq_err", 32'(bus.seq_err), 0);
    check("rst err_code", 32'(bus.err_code), 0);
    CLR = 1'b0;
    check("post-rst nclr low", 32'(bus.nclr_ring), 0);
    tick();
    check("post-rst nclr high", 32'(bus.nclr_ring), 1);
    check("post-rst idx", 32'(bus.tstate_idx), 1);
  endtask

  // Runs one instruction starting in its T01 cycle; exp_len is the clamped length
  task automatic do_instr(input logic [4:0] l, input bit v, input int exp_len,
                          input int corrupt_at, input int stop_at);
    for (int k = 1; k <= exp_len; k++) begin
      if (k == corrupt_at) begin
        bus.state = NS'(3);
        #1;
      end
      check($sformatf("L%0d idx T%0d", l, k), 32'(bus.tstate_idx), (k == corrupt_at) ? 0 : k);
      check($sformatf("L%0d done T%0d", l, k), 32'(bus.instr_done), (k == exp_len) ? 1 : 0);
      check($sformatf("L%0d nclr T%0d", l, k), 32'(bus.nclr_ring), (k == exp_len) ? 0 : 1);
      if (k == stop_at) return;
      if (k == FL) begin
        bus.len       = l;
        bus.len_valid = v;
      end
      tick();
      if (k == FL) begin
        bus.len       = 5'd2;
        bus.len_valid = 1'b1;
      end
    end
    check($sformatf("L%0d wrap to T01", l), 32'(bus.tstate_idx), 1);
    check($sformatf("L%0d seq_err", l), 32'(bus.seq_err), 0);
  endtask

`ifdef TSEQ_CHECK_EN
  // Drives a fault in T-state 'at' of a length-8 instruction and checks ERR behaviour
  task automatic err_run(input int at, input bit use_bad, input logic [NS-1:0] bad,
                         input bit lv, input logic [1:0] exp_code);
    for (int k = 1; k <= at; k++) begin
      if (k == FL) begin
        bus.len       = 5'd8;
        bus.len_valid = lv;
      end
      if (k == at && use_bad) begin
        bus.state = bad;
        #1;
      end
      if (k == at) check($sformatf("err%0d seq_err before edge", exp_code), 32'(bus.seq_err), 0);
      tick();
    end
    check($sformatf("err%0d seq_err", exp_code), 32'(bus.seq_err), 1);
    check($sformatf("err%0d code", exp_code), 32'(bus.err_code), 32'(exp_code));
    check($sformatf("err%0d nclr", exp_code), 32'(bus.nclr_ring), 0);
    check($sformatf("err%0d done", exp_code), 32'(bus.instr_done), 0);
    bus.len_valid = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check($sformatf("err%0d nclr held", exp_code), 32'(bus.nclr_ring), 0);
    check($sformatf("err%0d code sticky", exp_code), 32'(bus.err_code), 32'(exp_code));
    check($sformatf("err%0d seq_err sticky", exp_code), 32'(bus.seq_err), 1);
  endtask
`endif

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    CLR           = 1'b1;
    ring          = NS'(1) << 6;
    bus.state     = ring;
    bus.len       = 5'd0;
    bus.len_valid = 1'b0;

    do_reset(2);
    for (int r = 0; r < 3; r++) do_instr(5'd6, 1'b1, 6, 0, 0);
    do_instr(5'd2, 1'b1, 4, 0, 0);
    do_instr(5'd25, 1'b1, 18, 0, 0);
    do_instr(5'd4, 1'b1, 4, 0, 0);
    do_instr(5'd18, 1'b1, 18, 0, 0);

    // CLR in T09 of a 12-state instruction, then a fresh length
    do_instr(5'd12, 1'b1, 12, 0, 9);
    do_reset(1);
    do_instr(5'd5, 1'b1, 5, 0, 0);
    do_instr(5'd7, 1'b1, 7, 0, 0);

`ifdef TSEQ_CHECK_EN
    err_run(5, 1'b1, NS'(3), 1'b1, 2'b01);
    do_reset(2);
    err_run(5, 1'b1, NS'(1) << 5, 1'b1, 2'b10);
    do_reset(2);
    err_run(FL, 1'b0, '0, 1'b0, 2'b11);
    do_reset(2);
    err_run(FL, 1'b1, NS'(3), 1'b0, 2'b01);
    do_reset(2);
    do_instr(5'd6, 1'b1, 6, 0, 0);
`else
    do_instr(5'd9, 1'b0, 18, 0, 0);
    do_instr(5'd8, 1'b1, 8, 5, 0);
    do_instr(5'd6, 1'b1, 6, 0, 0);
    check("err_code tied", 32'(bus.err_code), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
